cpu32e2_bus_arbiter: RTL and testbench
======================================

// Module: cpu32e2_bus_arbiter
// PURPOSE
//  Shares one pipelined slave bus (waitRequest/readValid protocol) between two masters.
//  m0 is the cpu32e2 core; m1 is a second master such as a debug or DMA agent.
//  Round-robin grant; read responses are routed back in order via an ID FIFO.
//  Sits between the core bus pins and system RAM/peripherals.
// PARAMETERS
//  MAX_PENDING  4   max outstanding reads (ID FIFO depth, power of 2, >=2)
// PORTS
//  clk               in   1   clock
//  reset             in   1   async active-high reset
//  mN_read           in   1   read request (N=0,1)
//  mN_write          in   1   write request
//  mN_address        in   32  byte address
//  mN_byteWriteEnable in  4   byte lanes for write
//  mN_dataOut        in   32  write data
//  mN_waitRequest    out  1   stall: master must hold command while high
//  mN_readValid      out  1   mN_dataIn valid this cycle
//  mN_dataIn         out  32  read data (slave dataIn passthrough)
//  s_read/s_write    out  1   command to slave
//  s_address         out  32  muxed address
//  s_byteWriteEnable out  4   muxed lanes
//  s_dataOut         out  32  muxed write data
//  s_waitRequest     in   1   slave stall
//  s_readValid       in   1   slave read response
//  s_dataIn          in   32  slave read data
//  protocolError     out  1   sticky: s_readValid seen with empty ID FIFO
// BEHAVIOUR
//  - Reset: holdGrant=0, lastGrant=1 (m0 wins first), FIFO empty, protocolError=0.
//    All registered outputs are 0 at reset. mN_waitRequest=1 for any requesting master.
//  - Request: reqN = mN_read|mN_write. A read is blocked when the FIFO is full
//    (count==MAX_PENDING). A full FIFO blocks the read even if s_readValid pops this cycle.
//    A blocked read is not eligible for grant.
//  - Arbitration is combinational when holdGrant=0:
//    - both eligible -> master != lastGrant
//    - one eligible -> that master
//    - none -> no command, s_read=s_write=0.
//  - Hold: if the granted command sees s_waitRequest=1, set holdGrant=1 and latch the grant.
//    While holdGrant=1, only the latched master drives the slave; its inputs must be stable.
//  - Accept: command is accepted in the cycle where it is granted and s_waitRequest=0.
//    On accept:
//    - lastGrant <= granted master
//    - holdGrant <= 0
//    - read -> push master ID into FIFO
//  - mN_waitRequest = ~(granted to N && s_waitRequest==0). Non-granted masters are always stalled.
//  - read&write both high on one master: treated as write (no FIFO push).
//  - Response: on s_readValid, pop the FIFO head and assert m<head>_readValid the same cycle
//    (0 cycle latency). mN_dataIn = s_dataIn for both masters.
//    Push and pop in the same cycle: count unchanged.
//  - s_readValid with an empty FIFO: ignored (no pop, no mN_readValid); protocolError <= 1.
//    protocolError clears only on reset.
//  - Reset mid-transfer clears the FIFO and hold state. In-flight responses after reset raise
//    protocolError.
//  - FIFO pointers are log2(MAX_PENDING) bits and wrap naturally. count is log2(MAX_PENDING)+1 bits.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//  - Adds inputs m0_lock and m1_lock (1 bit each).
//  - While the current owner (lastGrant) holds lockN=1, the other master is ineligible.
//  - Lock is released when lockN drops.
//  ARB_LOCK_EN undefined: the lock ports do not exist; pure round-robin.
// TESTING
//  1. Reset, m0 read 0x10 only, s_waitRequest=0 -> s_read=1, s_address=0x10, m0_waitRequest=0;
//     s_readValid + s_dataIn=0xDEADBEEF -> m0_readValid=1, m0_dataIn=0xDEADBEEF.
//  2. m0 and m1 write continuously, s_waitRequest=0 -> grants alternate m0,m1,m0,m1
//     with no idle cycles.
//  3. m1 write with s_waitRequest=1 for 3 cycles while m0 requests -> grant stays m1
//     for 4 cycles, m0_waitRequest=1 throughout; m0 is granted next.
//  4. m0 issues 4 reads, no responses (MAX_PENDING=4) -> 5th read stalled;
//     m1 write still accepted; after one s_readValid the 5th read is accepted next cycle.
//  5. Interleaved reads m0,m1,m0, responses A,B,C -> A to m0, B to m1, C to m0, in order.
//  6. s_readValid with empty FIFO -> protocolError=1, no mN_readValid;
//     protocolError stays 1 until reset.
//     With ARB_LOCK_EN: m0_lock=1 over 3 writes -> m1 is starved until lock drops.

Source files
------------

// File: rtl/cpu32e2_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cpu32e2_bus_arbiter
//
// Lets two masters share one pipelined slave bus that uses the
// waitRequest/readValid handshake. m0 is the cpu32e2 core and m1 is a
// secondary agent such as a debug port or a DMA engine.
//
// Arbitration is round-robin. A command that the slave stalls keeps its
// grant until it is accepted. Every accepted read pushes the issuing
// master's ID into a small FIFO. Read responses come back in order, so
// the head of that FIFO names the master that owns each response.
//
// Parameters
//   MAX_PENDING  depth of the ID FIFO, which is the maximum number of
//                outstanding reads (power of 2, >= 2)
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   mN_read / mN_write         master command strobes (N = 0, 1)
//   mN_address                 byte address
//   mN_byteWriteEnable         write byte lanes
//   mN_dataOut                 write data
//   mN_waitRequest             stall back to the master
//   mN_readValid / mN_dataIn   read response to the master
//   s_read / s_write           command to the slave
//   s_address, s_byteWriteEnable, s_dataOut   muxed command fields
//   s_waitRequest              slave stall
//   s_readValid / s_dataIn     slave read response
//   protocolError              sticky flag: the slave responded while
//                              no read was outstanding
//
// Optional feature (macro ARB_LOCK_EN)
//   Adds m0_lock and m1_lock. While the master that won last holds its
//   lock high, the other master cannot win arbitration.
// ---------------------------------------------------------------------------
module cpu32e2_bus_arbiter #(
    parameter int MAX_PENDING = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef ARB_LOCK_EN
    input  logic        m0_lock,
    input  logic        m1_lock,
`endif
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_address,
    input  logic [3:0]  m0_byteWriteEnable,
    input  logic [31:0] m0_dataOut,
    output logic        m0_waitRequest,
    output logic        m0_readValid,
    output logic [31:0] m0_dataIn,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_address,
    input  logic [3:0]  m1_byteWriteEnable,
    input  logic [31:0] m1_dataOut,
    output logic        m1_waitRequest,
    output logic        m1_readValid,
    output logic [31:0] m1_dataIn,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_address,
    output logic [3:0]  s_byteWriteEnable,
    output logic [31:0] s_dataOut,
    input  logic        s_waitRequest,
    input  logic        s_readValid,
    input  logic [31:0] s_dataIn,
    output logic        protocolError
);

    localparam int AW = $clog2(MAX_PENDING);

    typedef enum logic {
        ARB_FREE,
        ARB_HOLD
    } arbState_t;

    arbState_t         state_q, state_d;
    logic              lastGrant_q, lastGrant_d;
    logic              heldMaster_q, heldMaster_d;
    logic              protocolError_q, protocolError_d;
    logic [AW:0]       count_q, count_d;
    logic [AW-1:0]     wrPtr_q, wrPtr_d;
    logic [AW-1:0]     rdPtr_q, rdPtr_d;
    logic [MAX_PENDING-1:0] fifoId_q, fifoId_d;

    logic fifoFull;
    logic req0, req1;
    logic rdOnly0, rdOnly1;
    logic elig0, elig1;
    logic grantValid, grantMaster;
    logic grantRead, grantWrite;
    logic accept, stall;
    logic push, pop;
    logic headId;

    // A write always qualifies. A read only qualifies while the ID FIFO has
    // room, and a pop in the same cycle does not count as room.
    always_comb begin
        fifoFull = (count_q == (AW+1)'(MAX_PENDING));
        req0     = m0_read | m0_write;
        req1     = m1_read | m1_write;
        rdOnly0  = m0_read & ~m0_write;
        rdOnly1  = m1_read & ~m1_write;
        elig0    = m0_write | (m0_read & ~fifoFull);
        elig1    = m1_write | (m1_read & ~fifoFull);
`ifdef ARB_LOCK_EN
        if (~lastGrant_q & m0_lock) begin
            elig1 = 1'b0;
        end
        if (lastGrant_q & m1_lock) begin
            elig0 = 1'b0;
        end
`endif
    end

    // Grant selection. A stalled command keeps its grant. Otherwise a tie
    // goes to the master that did not win last time. No grant is given
    // while reset is asserted, so every requester sees a stall.
    always_comb begin
        grantValid  = 1'b0;
        grantMaster = 1'b0;
        if (reset) begin
            grantValid = 1'b0;
        end else if (state_q == ARB_HOLD) begin
            grantMaster = heldMaster_q;
            grantValid  = heldMaster_q ? req1 : req0;
        end else if (elig0 & elig1) begin
            grantValid  = 1'b1;
            grantMaster = ~lastGrant_q;
        end else if (elig0) begin
            grantValid  = 1'b1;
            grantMaster = 1'b0;
        end else if (elig1) begin
            grantValid  = 1'b1;
            grantMaster = 1'b1;
        end
        accept = grantValid & ~s_waitRequest;
        stall  = grantValid & s_waitRequest;
    end

    // Hold FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Hold FSM: next state. The FSM leaves HOLD once the held command is
    // no longer stalled, including when the master has dropped it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_FREE: if (stall)  state_d = ARB_HOLD;
            ARB_HOLD: if (!stall) state_d = ARB_FREE;
            default:  state_d = ARB_FREE;
        endcase
    end

    // Hold FSM outputs: slave command mux, master stalls and response
    // steering. When read and write are both high, the command is a write.
    always_comb begin
        grantRead          = grantValid & (grantMaster ? rdOnly1 : rdOnly0);
        grantWrite         = grantValid & (grantMaster ? m1_write : m0_write);
        s_read             = grantRead;
        s_write            = grantWrite;
        s_address          = 32'h0;
        s_byteWriteEnable  = 4'h0;
        s_dataOut          = 32'h0;
        if (grantValid) begin
            s_address         = grantMaster ? m1_address : m0_address;
            s_byteWriteEnable = grantMaster ? m1_byteWriteEnable : m0_byteWriteEnable;
            s_dataOut         = grantMaster ? m1_dataOut : m0_dataOut;
        end
        m0_waitRequest = ~(accept & ~grantMaster);
        m1_waitRequest = ~(accept & grantMaster);
        headId         = fifoId_q[rdPtr_q];
        m0_readValid   = pop & ~headId;
        m1_readValid   = pop & headId;
        m0_dataIn      = s_dataIn;
        m1_dataIn      = s_dataIn;
        protocolError  = protocolError_q;
    end

    // Arbitration history and the ID FIFO. A response that arrives while
    // no read is outstanding is dropped and raises the sticky error flag.
    always_comb begin
        lastGrant_d     = lastGrant_q;
        heldMaster_d    = heldMaster_q;
        protocolError_d = protocolError_q;
        count_d         = count_q;
        wrPtr_d         = wrPtr_q;
        rdPtr_d         = rdPtr_q;
        fifoId_d        = fifoId_q;
        push            = accept & grantRead;
        pop             = s_readValid & (count_q != '0);

        if (stall) begin
            heldMaster_d = grantMaster;
        end
        if (accept) begin
            lastGrant_d = grantMaster;
        end
        if (s_readValid & (count_q == '0)) begin
            protocolError_d = 1'b1;
        end
        if (push) begin
            fifoId_d[wrPtr_q] = grantMaster;
            wrPtr_d           = wrPtr_q + AW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Datapath registers. lastGrant starts at 1 so that m0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastGrant_q     <= 1'b1;
            heldMaster_q    <= 1'b0;
            protocolError_q <= 1'b0;
            count_q         <= '0;
            wrPtr_q         <= '0;
            rdPtr_q         <= '0;
            fifoId_q        <= '0;
        end else begin
            lastGrant_q     <= lastGrant_d;
            heldMaster_q    <= heldMaster_d;
            protocolError_q <= protocolError_d;
            count_q         <= count_d;
            wrPtr_q         <= wrPtr_d;
            rdPtr_q         <= rdPtr_d;
            fifoId_q        <= fifoId_d;
        end
    end

endmodule

// File: tb/tb_cpu32e2_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu32e2_bus_arbiter
//
// Testbench for cpu32e2_bus_arbiter (default MAX_PENDING = 4). It runs:
//   - a vector table covering single reads, round-robin writes, a stalled
//     grant, a spurious response and a read+write collision
//   - hand-written sequences for FIFO-full blocking, in-order response
//     routing, reset mid-transfer and the optional lock
//   - a randomized phase checked against a queue-based reference model
// ---------------------------------------------------------------------------
module tb_cpu32e2_bus_arbiter;

    localparam int MAXP = 4;
    localparam logic [31:0] A0 = 32'h0000_0010;
    localparam logic [31:0] A1 = 32'h0000_0020;
    localparam logic [31:0] D0 = 32'hA0A0_0001;
    localparam logic [31:0] D1 = 32'hB1B1_0002;
    localparam logic [3:0]  B0 = 4'h3;
    localparam logic [3:0]  B1 = 4'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_address = A0, m1_address = A1, m0_dataOut = D0, m1_dataOut = D1;
    logic [3:0]  m0_byteWriteEnable = B0, m1_byteWriteEnable = B1;
    logic        m0_waitRequest, m0_readValid, m1_waitRequest, m1_readValid;
    logic [31:0] m0_dataIn, m1_dataIn;
    logic        s_read, s_write;
    logic [31:0] s_address, s_dataOut;
    logic [3:0]  s_byteWriteEnable;
    logic        s_waitRequest = 1'b0, s_readValid = 1'b0;
    logic [31:0] s_dataIn = 32'h0;
    logic        protocolError;
`ifdef ARB_LOCK_EN
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Stimulus bits {r0,w0,r1,w1,sWait,sRv}; expectation bits
    // {read,write,master,wait0,wait1,readValid0,readValid1,protocolError}.
    typedef struct {
        logic [5:0]  stim;
        logic [31:0] sData;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[18];

    // Random-phase reference model state
    int   q[$];
    bit   lastG, holding, heldM, err;
    bit   mr[2], mw[2], stalled[2];
    logic [31:0] ma[2], md[2];
    logic [3:0]  mb[2];

    always #5 clk = ~clk;

    cpu32e2_bus_arbiter #(.MAX_PENDING(MAXP)) dut (
        .clk(clk), .reset(reset),
`ifdef ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_byteWriteEnable(m0_byteWriteEnable), .m0_dataOut(m0_dataOut),
        .m0_waitRequest(m0_waitRequest), .m0_readValid(m0_readValid), .m0_dataIn(m0_dataIn),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_byteWriteEnable(m1_byteWriteEnable), .m1_dataOut(m1_dataOut),
        .m1_waitRequest(m1_waitRequest), .m1_readValid(m1_readValid), .m1_dataIn(m1_dataIn),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_byteWriteEnable(s_byteWriteEnable), .s_dataOut(s_dataOut),
        .s_waitRequest(s_waitRequest), .s_readValid(s_readValid), .s_dataIn(s_dataIn),
        .protocolError(protocolError)
    );

    task automatic applyStimulus(input logic r0, w0, r1, w1, sWait, sRv, input logic [31:0] sData);
        m0_read       = r0;
        m0_write      = w0;
        m1_read       = r1;
        m1_write      = w1;
        s_waitRequest = sWait;
        s_readValid   = sRv;
        s_dataIn      = sData;
    endtask

    // Address is compared only when a command is expected; write data and
    // lanes only when a write is expected.
    task automatic checkOutput(input string name, input logic eR, eW, ew0, ew1, erv0, erv1, eErr,
                               input logic [31:0] eAddr, eData, input logic [3:0] eBe);
        logic [138:0] act, exp;
        act = {s_read, s_write, m0_waitRequest, m1_waitRequest, m0_readValid, m1_readValid,
               protocolError, (eR | eW) ? s_address : 32'h0, eW ? s_dataOut : 32'h0,
               eW ? s_byteWriteEnable : 4'h0, m0_dataIn, m1_dataIn};
        exp = {eR, eW, ew0, ew1, erv0, erv1, eErr, (eR | eW) ? eAddr : 32'h0,
               eW ? eData : 32'h0, eW ? eBe : 4'h0, s_dataIn, s_dataIn};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input string name, input logic r0, w0, r1, w1, sWait, sRv,
                        input logic [31:0] sData,
                        input logic eR, eW, eM, ew0, ew1, erv0, erv1, eErr);
        @(negedge clk);
        applyStimulus(r0, w0, r1, w1, sWait, sRv, sData);
        #1;
        checkOutput(name, eR, eW, ew0, ew1, erv0, erv1, eErr,
                    eM ? A1 : A0, eM ? D1 : D0, eM ? B1 : B0);
    endtask

    // Reset with both masters requesting: nobody may be granted.
    task automatic doReset();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        applyStimulus(1, 0, 0, 1, 0, 0, 32'h0);
        #1;
        checkOutput("resetState", 0, 0, 1, 1, 0, 0, 0, A0, D0, B0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        int k;
        bit el[2], rq[2], rd[2];
        bit gv, g, acc, erv0, erv1;

        vecs[0]  = '{6'b000000, 32'h0,         8'b00011000};
        vecs[1]  = '{6'b100000, 32'h0,         8'b10001000};
        vecs[2]  = '{6'b000001, 32'hDEADBEEF,  8'b00011100};
        vecs[3]  = '{6'b010100, 32'h0,         8'b01110000};
        vecs[4]  = '{6'b010100, 32'h0,         8'b01001000};
        vecs[5]  = '{6'b010100, 32'h0,         8'b01110000};
        vecs[6]  = '{6'b010100, 32'h0,         8'b01001000};
        vecs[7]  = '{6'b010110, 32'h0,         8'b01111000};
        vecs[8]  = '{6'b010110, 32'h0,         8'b01111000};
        vecs[9]  = '{6'b010110, 32'h0,         8'b01111000};
        vecs[10] = '{6'b010100, 32'h0,         8'b01110000};
        vecs[11] = '{6'b010100, 32'h0,         8'b01001000};
        vecs[12] = '{6'b000001, 32'hCAFEF00D,  8'b00011000};
        vecs[13] = '{6'b000000, 32'h0,         8'b00011001};
        vecs[14] = '{6'b001000, 32'h0,         8'b10110001};
        vecs[15] = '{6'b110000, 32'h0,         8'b01001001};
        vecs[16] = '{6'b000001, 32'h12345678,  8'b00011011};
        vecs[17] = '{6'b000001, 32'h56789ABC,  8'b00011001};

        $display("[TB] vector table");
        doReset();
        for (int i = 0; i < 18; i++) begin
            step($sformatf("vec%0d", i), vecs[i].stim[5], vecs[i].stim[4], vecs[i].stim[3],
                 vecs[i].stim[2], vecs[i].stim[1], vecs[i].stim[0], vecs[i].sData,
                 vecs[i].exp[7], vecs[i].exp[6], vecs[i].exp[5], vecs[i].exp[4],
                 vecs[i].exp[3], vecs[i].exp[2], vecs[i].exp[1], vecs[i].exp[0]);
        end

        $display("[TB] FIFO full blocks reads");
        doReset();
        for (int i = 0; i < MAXP; i++) begin
            step($sformatf("fill%0d", i), 1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 1, 0, 0, 0);
        end
        step("fullWriteOk", 1, 0, 0, 1, 0, 0, 32'h0, 0, 1, 1, 1, 0, 0, 0, 0);
        step("fullPopStall", 1, 0, 0, 0, 0, 1, 32'h11, 0, 0, 0, 1, 1, 1, 0, 0);
        step("afterPopRead", 1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 1, 0, 0, 0);

        $display("[TB] in-order response routing");
        doReset();
        step("rdA", 1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 1, 0, 0, 0);
        step("rdB", 0, 0, 1, 0, 0, 0, 32'h0, 1, 0, 1, 1, 0, 0, 0, 0);
        step("rdC", 1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 1, 0, 0, 0);
        step("rspA", 0, 0, 0, 0, 0, 1, 32'hAAAA_0001, 0, 0, 0, 1, 1, 1, 0, 0);
        step("rspB", 0, 0, 0, 0, 0, 1, 32'hBBBB_0002, 0, 0, 0, 1, 1, 0, 1, 0);
        step("rspC", 0, 0, 0, 0, 0, 1, 32'hCCCC_0003, 0, 0, 0, 1, 1, 1, 0, 0);

        $display("[TB] reset mid-transfer");
        step("midRd0", 1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 1, 0, 0, 0);
        step("midRd1", 0, 0, 1, 0, 0, 0, 32'h0, 1, 0, 1, 1, 0, 0, 0, 0);
        step("midIdle", 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 1, 0, 0, 0);
        doReset();
        step("staleRsp", 0, 0, 0, 0, 0, 1, 32'h0BAD, 0, 0, 0, 1, 1, 0, 0, 0);
        step("staleErr", 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 1, 0, 0, 1);

`ifdef ARB_LOCK_EN
        $display("[TB] lock starves the other master");
        doReset();
        m0_lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("lock%0d", i), 0, 1, 0, 1, 0, 0, 32'h0, 0, 1, 0, 0, 1, 0, 0, 0);
        end
        @(negedge clk);
        m0_lock = 1'b0;
        applyStimulus(0, 1, 0, 1, 0, 0, 32'h0);
        #1;
        checkOutput("unlock", 0, 1, 1, 0, 0, 0, 0, A1, D1, B1);
`endif

        $display("[TB] randomized phase");
        doReset();
        q.delete();
        lastG = 1'b1;
        holding = 1'b0;
        heldM = 1'b0;
        err = 1'b0;
        stalled[0] = 1'b0;
        stalled[1] = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!stalled[i]) begin
                    k     = $urandom_range(0, 7);
                    mr[i] = (k == 1 || k == 2 || k == 7);
                    mw[i] = (k == 3 || k == 4 || k == 7);
                    ma[i] = $urandom;
                    md[i] = $urandom;
                    mb[i] = 4'($urandom);
                end
            end
            m0_address = ma[0]; m0_dataOut = md[0]; m0_byteWriteEnable = mb[0];
            m1_address = ma[1]; m1_dataOut = md[1]; m1_byteWriteEnable = mb[1];
            applyStimulus(mr[0], mw[0], mr[1], mw[1], $urandom_range(0, 3) == 0,
                          (q.size() > 0) && ($urandom_range(0, 1) == 1), $urandom);

            for (int i = 0; i < 2; i++) begin
                rq[i] = mr[i] | mw[i];
                rd[i] = mr[i] & ~mw[i];
                el[i] = mw[i] | (mr[i] && q.size() < MAXP);
            end
            gv = 1'b0;
            g  = 1'b0;
            if (holding) begin
                g  = heldM;
                gv = rq[heldM];
            end else if (el[0] && el[1]) begin
                gv = 1'b1;
                g  = ~lastG;
            end else if (el[0] || el[1]) begin
                gv = 1'b1;
                g  = el[1];
            end
            acc  = gv && !s_waitRequest;
            erv0 = s_readValid && q.size() > 0 && q[0] == 0;
            erv1 = s_readValid && q.size() > 0 && q[0] == 1;
            #1;
            checkOutput($sformatf("rand%0d", cyc), gv && rd[g], gv && mw[g],
                        !(acc && g == 0), !(acc && g == 1), erv0, erv1, err, ma[g], md[g], mb[g]);

            if (s_readValid) begin
                if (q.size() > 0) void'(q.pop_front());
                else err = 1'b1;
            end
            if (acc) begin
                lastG   = g;
                holding = 1'b0;
                if (rd[g]) q.push_back(int'(g));
            end else if (gv) begin
                holding = 1'b1;
                heldM   = g;
            end
            for (int i = 0; i < 2; i++) begin
                stalled[i] = rq[i] && !(acc && g == i);
            end
        end

        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
